nvdla_sdp_cmux_src_sel: RTL and testbench

Upstream feeder of the SDP cmux output pipe. It selects one of two 512-bit data sources per layer: the CACC stream in flying mode, or the MRDMA read stream otherwise. It counts the beats of the layer against a programmed total and presents them on a registered valid/ready interface (`cmux2dp_*`). That interface drives the downstream skid/pipe stage directly. A one-cycle `op_done` pulse marks the point where the layer's last beat has left the block.

---
 rtl/nvdla_sdp_cmux_src_sel.sv | 170 +++++++++++++++++
 tb/tb_nvdla_sdp_cmux_src_sel.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nvdla_sdp_cmux_src_sel.sv
// nvdla_sdp_cmux_src_sel
// Per-layer source selector feeding the SDP cmux output pipe. Picks the
// CACC stream (flying mode) or the MRDMA stream, counts beats against the
// programmed total and presents them through a registered valid/ready stage.
// Optional build macro: NVDLA_SDP_CMUX_SRC_SEL_PERF_EN adds perf_stall_cnt.
module nvdla_sdp_cmux_src_sel #(
    parameter int unsigned DW    = 512,
    parameter int unsigned CNT_W = 32
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rst,
    input  logic             op_en,
    input  logic             flying_mode,
    input  logic [CNT_W-1:0] total_cnt,
    input  logic [DW-1:0]    cacc2sdp_pd,
    input  logic             cacc2sdp_valid,
    output logic             cacc2sdp_ready,
    input  logic [DW-1:0]    mrdma2cmux_pd,
    input  logic             mrdma2cmux_valid,
    output logic             mrdma2cmux_ready,
    output logic [DW-1:0]    cmux2dp_pd,
    output logic             cmux2dp_pvld,
    input  logic             cmux2dp_prdy,
`ifdef NVDLA_SDP_CMUX_SRC_SEL_PERF_EN
    output logic [31:0]      perf_stall_cnt,
`endif
    output logic             busy,
    output logic             op_done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             sel_q, sel_d;
    logic [CNT_W-1:0] tot_q, tot_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             pvld_q, pvld_d;
    logic [DW-1:0]    pd_q, pd_d;
    logic             op_done_q, op_done_d;

    logic             out_ready;
    logic             in_run;
    logic             src_valid;
    logic [DW-1:0]    src_pd;
    logic             src_hs;
    logic             last_beat;

    // Source mux and handshake; readies depend only on state, pvld and prdy
    always_comb begin
        out_ready        = !pvld_q || cmux2dp_prdy;
        in_run           = (state_q == ST_RUN);
        src_valid        = sel_q ? cacc2sdp_valid : mrdma2cmux_valid;
        src_pd           = sel_q ? cacc2sdp_pd : mrdma2cmux_pd;
        src_hs           = in_run && src_valid && out_ready;
        last_beat        = (beat_cnt_q == tot_q);
        cacc2sdp_ready   = in_run && sel_q && out_ready;
        mrdma2cmux_ready = in_run && !sel_q && out_ready;
    end

    // Layer control: config latch, beat counting and IDLE/RUN/DRAIN sequencing
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        tot_d      = tot_q;
        beat_cnt_d = beat_cnt_q;
        op_done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (op_en) begin
                    sel_d      = flying_mode;
                    tot_d      = total_cnt;
                    beat_cnt_d = '0;
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                // The last beat leaves the counter at tot so it never wraps,
                // even when tot is the all-ones maximum.
                if (src_hs) begin
                    if (last_beat) begin
                        state_d = ST_DRAIN;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (!pvld_q || cmux2dp_prdy) begin
                    state_d   = ST_IDLE;
                    op_done_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output pipe register: reload on source handshake, empty on consume
    always_comb begin
        pvld_d = pvld_q;
        pd_d   = pd_q;
        if (src_hs) begin
            pvld_d = 1'b1;
            pd_d   = src_pd;
        end else if (cmux2dp_prdy) begin
            pvld_d = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            state_q    <= ST_IDLE;
            sel_q      <= 1'b0;
            tot_q      <= '0;
            beat_cnt_q <= '0;
            pvld_q     <= 1'b0;
            pd_q       <= '0;
            op_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            tot_q      <= tot_d;
            beat_cnt_q <= beat_cnt_d;
            pvld_q     <= pvld_d;
            pd_q       <= pd_d;
            op_done_q  <= op_done_d;
        end
    end

    // Output drive
    always_comb begin
        cmux2dp_pvld = pvld_q;
        cmux2dp_pd   = pd_q;
        busy         = (state_q != ST_IDLE);
        op_done      = op_done_q;
    end

`ifdef NVDLA_SDP_CMUX_SRC_SEL_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles where a held beat is back-pressured
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q == ST_IDLE && op_en) begin
            stall_cnt_d = '0;
        end else if (busy && pvld_q && !cmux2dp_prdy && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Stall counter register
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Stall counter drive
    always_comb begin
        perf_stall_cnt = stall_cnt_q;
    end
`endif

endmodule

// File: tb/tb_nvdla_sdp_cmux_src_sel.sv
// Scoreboard bench for nvdla_sdp_cmux_src_sel: the driver queues each
// layer's payloads in source order, the monitor pops and compares on every
// output handshake and tracks op_done/busy/ready expectations.
module tb_nvdla_sdp_cmux_src_sel;

    localparam int DW    = 512;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             op_en;
    logic             flying_mode;
    logic [CNT_W-1:0] total_cnt;
    logic [DW-1:0]    cacc2sdp_pd;
    logic             cacc2sdp_valid;
    logic             cacc2sdp_ready;
    logic [DW-1:0]    mrdma2cmux_pd;
    logic             mrdma2cmux_valid;
    logic             mrdma2cmux_ready;
    logic [DW-1:0]    cmux2dp_pd;
    logic             cmux2dp_pvld;
    logic             cmux2dp_prdy;
    logic             busy;
    logic             op_done;
`ifdef NVDLA_SDP_CMUX_SRC_SEL_PERF_EN
    logic [31:0]      perf_stall_cnt;
`endif

    nvdla_sdp_cmux_src_sel #(.DW(DW), .CNT_W(CNT_W)) dut (
        .nvdla_core_clk   (clk),
        .nvdla_core_rst   (rst),
        .op_en            (op_en),
        .flying_mode      (flying_mode),
        .total_cnt        (total_cnt),
        .cacc2sdp_pd      (cacc2sdp_pd),
        .cacc2sdp_valid   (cacc2sdp_valid),
        .cacc2sdp_ready   (cacc2sdp_ready),
        .mrdma2cmux_pd    (mrdma2cmux_pd),
        .mrdma2cmux_valid (mrdma2cmux_valid),
        .mrdma2cmux_ready (mrdma2cmux_ready),
        .cmux2dp_pd       (cmux2dp_pd),
        .cmux2dp_pvld     (cmux2dp_pvld),
        .cmux2dp_prdy     (cmux2dp_prdy),
`ifdef NVDLA_SDP_CMUX_SRC_SEL_PERF_EN
        .perf_stall_cnt   (perf_stall_cnt),
`endif
        .busy             (busy),
        .op_done          (op_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Scoreboard state shared by driver and monitor
    logic [DW-1:0] exp_q[$];
    int            layer_left = 0;
    bit            done_exp   = 1'b0;
    bit            exp_busy   = 1'b0;
    bit            cur_sel    = 1'b0;
    bit            mon_en     = 1'b0;
    int            pops       = 0;
    time           first_pop_t, last_pop_t, first_acc_t;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [DW-1:0] rnd();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Monitor: samples mid-cycle, so a pvld&&prdy seen here completes at the next edge
    always @(negedge clk) begin
        logic [DW-1:0] exp_d;
        if (mon_en && !rst) begin
            if (done_exp) exp_busy = 1'b0;
            chk("op_done", DW'(op_done), DW'(done_exp));
            done_exp = 1'b0;
            chk("busy", DW'(busy), DW'(exp_busy));
            if (!exp_busy) begin
                chk("idle_cacc_ready", DW'(cacc2sdp_ready), '0);
                chk("idle_mrdma_ready", DW'(mrdma2cmux_ready), '0);
                chk("idle_pvld", DW'(cmux2dp_pvld), '0);
            end else begin
                chk("unsel_ready", DW'(cur_sel ? mrdma2cmux_ready : cacc2sdp_ready), '0);
            end
            if (cmux2dp_pvld && cmux2dp_prdy) begin
                chk("beat_expected", DW'(exp_q.size() > 0), DW'(1));
                if (exp_q.size() > 0) begin
                    exp_d = exp_q.pop_front();
                    chk("out_pd", cmux2dp_pd, exp_d);
                    if (pops == 0) first_pop_t = $time;
                    last_pop_t = $time;
                    pops++;
                    layer_left--;
                    if (layer_left == 0) done_exp = 1'b1;
                end
            end
        end
    end

    // prdy_mode: 0 = always ready, 1 = random, 2 = hold off for 5 stalled cycles
    task automatic run_layer(input bit sel, input int tot, input int prdy_mode, input int vld_pct,
                             input int glitch_at, input int rst_at, input bit chain);
        logic [DW-1:0] data[$];
        logic [DW-1:0] d, spd;
        int  idx, cycles, stalls;
        bit  sv, sready, aborted;
        data.delete();
        for (int k = 0; k <= tot; k++) begin
            d = rnd();
            data.push_back(d);
            exp_q.push_back(d);
        end
        layer_left = tot + 1;
        pops = 0;
        cacc2sdp_valid = 1'b0;
        mrdma2cmux_valid = 1'b0;
        op_en = 1'b1;
        flying_mode = sel;
        total_cnt = CNT_W'(tot);
        cur_sel = sel;
        @(posedge clk); #1;
        op_en = 1'b0;
        exp_busy = 1'b1;
        idx = 0; cycles = 0; stalls = 0; aborted = 1'b0;
        while (layer_left != 0 && cycles < 3000) begin
            sv  = (idx <= tot) && ($urandom_range(99) < vld_pct);
            spd = (idx <= tot) ? data[idx] : rnd();
            if (sel) begin
                cacc2sdp_valid = sv; cacc2sdp_pd = spd;
                mrdma2cmux_valid = 1'($urandom_range(1)); mrdma2cmux_pd = rnd();
            end else begin
                mrdma2cmux_valid = sv; mrdma2cmux_pd = spd;
                cacc2sdp_valid = 1'($urandom_range(1)); cacc2sdp_pd = rnd();
            end
            case (prdy_mode)
                0:       cmux2dp_prdy = 1'b1;
                1:       cmux2dp_prdy = 1'($urandom_range(1));
                default: cmux2dp_prdy = (stalls >= 5);
            endcase
            if (cycles == glitch_at) begin
                op_en = 1'b1; flying_mode = !sel; total_cnt = CNT_W'(tot + 7);
            end else begin
                op_en = 1'b0;
            end
            if (rst_at >= 0 && idx == rst_at) begin
                rst = 1'b1; cmux2dp_prdy = 1'b0;
            end
            @(negedge clk);
            if (rst) begin
                aborted = 1'b1;
                break;
            end
            sready = sel ? cacc2sdp_ready : mrdma2cmux_ready;
            if (idx > tot) chk("drain_src_ready", DW'(sready), '0);
            if (sv && sready) begin
                if (idx == 0) first_acc_t = $time;
                idx++;
            end
            if (prdy_mode == 2 && cmux2dp_pvld && !cmux2dp_prdy && exp_q.size() > 0) begin
                chk("held_pd", cmux2dp_pd, exp_q[0]);
                stalls++;
            end
            @(posedge clk); #1;
            cycles++;
        end
        op_en = 1'b0;
        if (aborted) begin
            @(posedge clk); #1;
            rst = 1'b0;
            exp_q.delete();
            layer_left = 0;
            exp_busy = 1'b0;
            done_exp = 1'b0;
            cacc2sdp_valid = 1'b1;
            mrdma2cmux_valid = 1'b1;
            cmux2dp_prdy = 1'b1;
            repeat (3) begin @(posedge clk); #1; end
            cacc2sdp_valid = 1'b0;
            mrdma2cmux_valid = 1'b0;
        end else begin
            chk("layer_beats_left", DW'(layer_left), '0);
            if (!chain) begin
                cacc2sdp_valid = 1'b0;
                mrdma2cmux_valid = 1'b0;
                repeat (3) begin @(posedge clk); #1; end
            end
        end
    endtask

    initial begin
        rst = 1'b1; op_en = 1'b0; flying_mode = 1'b0; total_cnt = '0;
        cacc2sdp_pd = '0; cacc2sdp_valid = 1'b0;
        mrdma2cmux_pd = '0; mrdma2cmux_valid = 1'b0;
        cmux2dp_prdy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pvld", DW'(cmux2dp_pvld), '0);
        chk("rst_pd", cmux2dp_pd, '0);
        chk("rst_cacc_ready", DW'(cacc2sdp_ready), '0);
        chk("rst_mrdma_ready", DW'(mrdma2cmux_ready), '0);
        chk("rst_busy", DW'(busy), '0);
        chk("rst_op_done", DW'(op_done), '0);
`ifdef NVDLA_SDP_CMUX_SRC_SEL_PERF_EN
        chk("rst_perf", DW'(perf_stall_cnt), '0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // Idle with both sources valid: nothing may pass
        for (int i = 0; i < 5; i++) begin
            cacc2sdp_valid = 1'b1; cacc2sdp_pd = rnd();
            mrdma2cmux_valid = 1'b1; mrdma2cmux_pd = rnd();
            cmux2dp_prdy = 1'($urandom_range(1));
            @(posedge clk); #1;
        end

        // Flying mode, 4 beats at full throughput
        run_layer(1'b1, 3, 0, 100, -1, -1, 1'b0);
        chk("first_latency", DW'(first_pop_t - first_acc_t), DW'(10));
        chk("back_to_back", DW'(last_pop_t - first_pop_t), DW'(30));
`ifdef NVDLA_SDP_CMUX_SRC_SEL_PERF_EN
        chk("perf_no_stall", DW'(perf_stall_cnt), '0);
`endif

        // MRDMA single beat, held 5 cycles
        run_layer(1'b0, 0, 2, 100, -1, -1, 1'b0);
`ifdef NVDLA_SDP_CMUX_SRC_SEL_PERF_EN
        chk("perf_stall_5", DW'(perf_stall_cnt), DW'(5));
`endif

        // Random toggling over 100 beats
        run_layer(1'($urandom_range(1)), 99, 1, 60, -1, -1, 1'b0);

        // op_en during RUN is ignored
        run_layer(1'b1, 10, 1, 70, 3, -1, 1'b0);

        // Back-to-back layers: new op_en in the op_done cycle
        run_layer(1'b0, 5, 0, 100, -1, -1, 1'b1);
        run_layer(1'b1, 2, 1, 80, -1, -1, 1'b0);

        // Reset after 2 of 8 beats, then a clean layer
        run_layer(1'($urandom_range(1)), 7, 1, 80, -1, 2, 1'b0);
        run_layer(1'b0, 7, 1, 80, -1, -1, 1'b0);

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
